// File: rtl/mul_div_unit_if.sv
// Issue/result bundle between the MIPS control path and the HI/LO multiply-divide unit.
// The master side issues operations and moves; the slave side owns HI/LO and status.
interface mul_div_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    modport master (output start, op, a, b, mthi, mtlo,
                    input  hi, lo, busy, done);
    modport slave  (input  start, op, a, b, mthi, mtlo,
                    output hi, lo, busy, done);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit owning the HI/LO pair; fixed 32-cycle latency.
// Operands are reduced to magnitudes at accept and the sign is restored on the final edge.
module mul_div_unit (
    input  logic          clk,
    input  logic          clrn,
    mul_div_unit_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic        div_q;      // 1: divide, 0: multiply
    logic        neg_res_q;  // product / quotient negated
    logic        neg_rem_q;  // remainder takes dividend sign
    logic [31:0] opnd_q;     // multiplicand or divisor magnitude
    logic [63:0] acc_q;      // {partial/remainder, multiplier/quotient}
    logic [4:0]  cnt_q;
    logic [31:0] hi_q, lo_q;
    logic        done_q;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [63:0] acc_d;
    logic [63:0] prod;
    logic [31:0] quot, rem;
    logic [31:0] res_hi, res_lo;
    logic        last;

    // Only the signed ops (op[0]=0) take absolute values.
    assign a_neg = ~bus.op[0] & bus.a[31];
    assign b_neg = ~bus.op[0] & bus.b[31];
    assign a_mag = a_neg ? -bus.a : bus.a;
    assign b_mag = b_neg ? -bus.b : bus.b;

    assign last = (state_q == RUN) && (cnt_q == 5'd31);

    // NOTE: every signal written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN:  if (cnt_q == 5'd31) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    // The 34-bit difference keeps the borrow correct even for a zero divisor.
    always_comb begin
        mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
        div_shift = {acc_q[63:32], acc_q[31]};
        div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
        acc_d     = {mul_sum, acc_q[31:1]};
        if (div_q) begin
            if (!div_diff[33]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
            else               acc_d = {div_shift[31:0], acc_q[30:0], 1'b0};
        end
    end

    // Sign correction applied to the value produced by the 32nd iteration.
    always_comb begin
        prod   = neg_res_q ? -acc_d : acc_d;
        quot   = acc_d[31:0];
        rem    = acc_d[63:32];
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (div_q) begin
            res_hi = neg_rem_q ? -rem : rem;
            res_lo = (opnd_q == 32'd0) ? 32'hFFFF_FFFF : (neg_res_q ? -quot : quot);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opnd_q    <= 32'd0;
            acc_q     <= 64'd0;
            cnt_q     <= 5'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        div_q     <= bus.op[1];
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        cnt_q     <= 5'd0;
                        if (bus.op[1]) begin
                            acc_q  <= {32'd0, a_mag};
                            opnd_q <= b_mag;
                        end else begin
                            acc_q  <= {32'd0, b_mag};
                            opnd_q <= a_mag;
                        end
                    end else begin
                        if (bus.mthi) hi_q <= bus.a;
                        if (bus.mtlo) lo_q <= bus.a;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (last) begin
                        hi_q   <= res_hi;
                        lo_q   <= res_lo;
                        done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: expected HI/LO come from an arithmetic reference model
// pushed to a scoreboard at issue and popped when done pulses.
module tb_mul_div_unit;
    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    mul_div_unit_if bus ();
    mul_div_unit dut (.clk(clk), .clrn(clrn), .bus(bus));

    int unsigned cycles = 0;
    always @(posedge clk) cycles <= cycles + 1;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned t_acc;
    logic [31:0] last_hi, last_lo;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] da, db;
        da = a;
        db = b;
        case (op)
            MULT: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            MULTU: return {32'd0, a} * {32'd0, b};
            DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(da % db), 32'(da / db)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input logic with_mtlo);
        exp_t        e;
        logic [63:0] m;
        m     = model(op, a, b);
        e.tag = tag;
        e.hi  = m[63:32];
        e.lo  = m[31:0];
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.mtlo  = with_mtlo;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mtlo  = 1'b0;
        t_acc     = cycles;
        // Operands must have been captured at the accept edge only.
        bus.a     = ~a;
        bus.b     = ~b;
        bus.op    = ~op;
        check({tag, "_busy_on"}, bus.busy, 1);
    endtask

    task automatic wait_result();
        exp_t e;
        int   n;
        n = 0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        check({e.tag, "_done"}, bus.done, 1);
        check({e.tag, "_latency"}, cycles - t_acc, 32);
        check({e.tag, "_busy_off"}, bus.busy, 0);
        check({e.tag, "_hi"}, bus.hi, e.hi);
        check({e.tag, "_lo"}, bus.lo, e.lo);
        last_hi = e.hi;
        last_lo = e.lo;
        @(negedge clk);
        check({e.tag, "_done_pulse"}, bus.done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        #22;
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        @(negedge clk);
        clrn = 1'b1;

        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 1'b0); wait_result();
        issue(MULT,  32'hFFFF_FFFD, 32'h0000_0005, "mult_neg3x5", 1'b0); wait_result();
        issue(MULT,  32'h8000_0000, 32'h8000_0000, "mult_min2", 1'b0); wait_result();
        issue(DIV,   32'hFFFF_FFF9, 32'h0000_0002, "div_neg7_2", 1'b0); wait_result();
        issue(DIVU,  32'd100,       32'd7,         "divu_100_7", 1'b0); wait_result();
        issue(DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0); wait_result();
        issue(DIVU,  32'd7,         32'd0,         "divu_by0", 1'b0); wait_result();
        issue(DIV,   32'hFFFF_FFFB, 32'd0,         "div_neg5_by0", 1'b0); wait_result();
        issue(DIV,   32'd1000,      32'hFFFF_FFFD, "div_1000_neg3", 1'b0); wait_result();

        // Idle moves.
        @(negedge clk);
        bus.a    = 32'h1234_5678;
        bus.mthi = 1'b1;
        @(negedge clk);
        bus.mthi = 1'b0;
        check("mthi_hi", bus.hi, 32'h1234_5678);
        check("mthi_lo_kept", bus.lo, last_lo);
        bus.a    = 32'hCAFE_F00D;
        bus.mthi = 1'b1;
        bus.mtlo = 1'b1;
        @(negedge clk);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
        check("mtboth_hi", bus.hi, 32'hCAFE_F00D);
        check("mtboth_lo", bus.lo, 32'hCAFE_F00D);
        last_hi = 32'hCAFE_F00D;
        last_lo = 32'hCAFE_F00D;

        // Start, moves and new operands while busy are all ignored.
        issue(DIVU, 32'd1000, 32'd3, "busy_ignore", 1'b0);
        bus.start = 1'b1;
        bus.op    = MULTU;
        bus.a     = 32'h0000_0055;
        bus.b     = 32'h0000_0005;
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        check("busy_hold_hi", bus.hi, last_hi);
        check("busy_hold_lo", bus.lo, last_lo);
        wait_result();

        // Start with mtlo in idle: the operation wins, the move is dropped.
        issue(MULT, 32'hFFFF_FFFD, 32'h0000_0005, "start_mtlo", 1'b1); wait_result();

        // Reset mid-run aborts the operation.
        issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "abort", 1'b0);
        repeat (14) @(negedge clk);
        #2 clrn = 1'b0;
        #1;
        check("abort_hi", bus.hi, 0);
        check("abort_lo", bus.lo, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        void'(sb.pop_front());
        @(negedge clk);
        clrn = 1'b1;
        issue(MULTU, 32'd6, 32'd7, "multu_6x7", 1'b0); wait_result();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
